// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared pixel colour constants, classifier and dilation state type
package img_pkg;

    localparam logic WHITE = 1'b1;
    localparam logic BLACK = 1'b0;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        DRAIN
    } dil_state_t;

    // A pixel is white only when every one of its low 'width' bits is set.
    function automatic logic is_white(input logic [63:0] pix, input int unsigned width);
        logic [63:0] ones;
        ones = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return pix == ones;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - DEPTH-deep 1-bit delay line advanced on enable
module line_buffer #(
    parameter int DEPTH = 320
) (
    input  logic clk,
    input  logic en,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    // Contents are not cleared; stale rows are masked by the caller's row counter.
    always_ff @(posedge clk) begin
        if (en) begin
            sr <= {sr[DEPTH-2:0], din};
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/dilation.sv
// rtl/dilation.sv - streaming 3x3 binary dilation of a raster pixel stream
module dilation
    import img_pkg::*;
#(
    parameter int IMAGE_WIDTH      = 320,
    parameter int IMAGE_HEIGHT     = 464,
    parameter int DATA_WIDTH       = 8,
    parameter int BACKGROUND_COLOR = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pixel_valid,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    output logic                  pixel_out_valid,
    output logic [DATA_WIDTH-1:0] pixel_out
);

    localparam int COL_W = $clog2(IMAGE_WIDTH);
    localparam int ROW_W = $clog2(IMAGE_HEIGHT);
    localparam logic FG = (BACKGROUND_COLOR != 0) ? BLACK : WHITE;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMAGE_HEIGHT - 1);

    dil_state_t state, state_nxt;
    logic [COL_W-1:0] in_col, out_col;
    logic [ROW_W-1:0] in_row, out_row;
    logic accept, advance, emit, cur_bit, lb1_out, lb2_out, hit;
    logic top, bottom, left, right;
    // Window columns: bit0 = row r-1, bit1 = row r, bit2 = row r+1 (1 = foreground)
    logic [2:0] w0, w1, col_new, row_mask;

    line_buffer #(.DEPTH(IMAGE_WIDTH)) u_lb1 (
        .clk  (clk),
        .en   (advance),
        .din  (cur_bit),
        .dout (lb1_out)
    );

    line_buffer #(.DEPTH(IMAGE_WIDTH)) u_lb2 (
        .clk  (clk),
        .en   (advance),
        .din  (lb1_out),
        .dout (lb2_out)
    );

    always_comb begin
        state_nxt = state;
        accept    = pixel_valid && (state != DRAIN);
        // Drain keeps the pipeline moving with background pixels shifted in.
        advance   = accept || (state == DRAIN);
        emit      = advance && (state != FILL);
        cur_bit   = (state == DRAIN) ? 1'b0 : (is_white(64'(pixel_in), DATA_WIDTH) == FG);
        case (state)
            FILL: begin
                if (accept && in_row == ROW_W'(1) && in_col == '0) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (accept && in_row == LAST_ROW && in_col == LAST_COL) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_row == LAST_ROW && out_col == LAST_COL) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        col_new  = {cur_bit, lb1_out, lb2_out};
        top      = (out_row == '0);
        bottom   = (out_row == LAST_ROW);
        left     = (out_col == '0);
        right    = (out_col == LAST_COL);
        row_mask = {~bottom, 1'b1, ~top};
        hit      = |((w0 & row_mask & {3{~left}})
                   | (w1 & row_mask)
                   | (col_new & row_mask & {3{~right}}));
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            w0 <= w1;
            w1 <= col_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= FILL;
            in_col          <= '0;
            in_row          <= '0;
            out_col         <= '0;
            out_row         <= '0;
            pixel_out_valid <= 1'b0;
            pixel_out       <= '0;
        end else begin
            state           <= state_nxt;
            pixel_out_valid <= emit;
            if (accept) begin
                if (in_col == LAST_COL) begin
                    in_col <= '0;
                    in_row <= (in_row == LAST_ROW) ? '0 : in_row + 1'b1;
                end else begin
                    in_col <= in_col + 1'b1;
                end
            end
            if (emit) begin
                pixel_out <= hit ? {DATA_WIDTH{FG}} : {DATA_WIDTH{~FG}};
                if (out_col == LAST_COL) begin
                    out_col <= '0;
                    out_row <= (out_row == LAST_ROW) ? '0 : out_row + 1'b1;
                end else begin
                    out_col <= out_col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dilation.sv
// tb/tb_dilation.sv - directed self-checking bench for dilation (both background polarities)
module tb_dilation;

    localparam int W = 16;
    localparam int H = 12;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst;
    logic       v0, v1;
    logic [7:0] p0, p1;
    logic       ov0, ov1;
    logic [7:0] po0, po1;

    logic [7:0] img [H][W];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int sent, first0, first1, snap;
    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    dilation #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DATA_WIDTH(8), .BACKGROUND_COLOR(0)) u_dil_bg0 (
        .clk             (clk),
        .rst             (rst),
        .pixel_valid     (v0),
        .pixel_in        (p0),
        .pixel_out_valid (ov0),
        .pixel_out       (po0)
    );

    dilation #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DATA_WIDTH(8), .BACKGROUND_COLOR(1)) u_dil_bg1 (
        .clk             (clk),
        .rst             (rst),
        .pixel_valid     (v1),
        .pixel_in        (p1),
        .pixel_out_valid (ov1),
        .pixel_out       (po1)
    );

    always @(negedge clk) begin
        if (ov0) begin
            if (q0.size() == 0) first0 = sent;
            q0.push_back(po0);
        end
        if (ov1) begin
            if (q1.size() == 0) first1 = sent;
            q1.push_back(po1);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qv(input int inst, input int idx);
        if (inst == 0) return (idx < q0.size()) ? 32'(q0[idx]) : 'x;
        return (idx < q1.size()) ? 32'(q1[idx]) : 'x;
    endfunction

    function automatic logic [7:0] model(input int bg, input int r, input int c);
        logic any_fg = 1'b0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W) begin
                    if ((img[r+dr][c+dc] == 8'hFF) == (bg == 0)) any_fg = 1'b1;
                end
            end
        end
        if (bg != 0) return any_fg ? 8'h00 : 8'hFF;
        return any_fg ? 8'hFF : 8'h00;
    endfunction

    task automatic fill_img(input logic [7:0] val);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = val;
    endtask

    task automatic drive(input int inst, input logic v, input logic [7:0] p);
        if (inst == 0) begin v0 = v; p0 = p; end
        else begin v1 = v; p1 = p; end
    endtask

    // Feeds img, checks first-output latency and drain length; queue holds the frame afterwards.
    task automatic send(input int inst, input bit gaps, input string tag);
        if (inst == 0) q0.delete(); else q1.delete();
        first0 = -1;
        first1 = -1;
        sent = 0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            drive(inst, 1'b1, img[k / W][k % W]);
            @(posedge clk);
            sent++;
            if (gaps && k != N - 1) begin
                @(negedge clk);
                drive(inst, 1'b0, 8'h00);
                @(posedge clk);
            end
        end
        @(negedge clk);
        drive(inst, 1'b0, 8'h00);
        #1;
        snap = (inst == 0) ? q0.size() : q1.size();
        repeat (W + 8) @(negedge clk);
        #1;
        check({tag, " first_latency"}, (inst == 0) ? first0 : first1, W + 2);
        check({tag, " drain_count"}, ((inst == 0) ? q0.size() : q1.size()) - snap, W + 1);
    endtask

    task automatic check_frame(input int inst, input int bg, input string tag);
        check({tag, " out_count"}, (inst == 0) ? q0.size() : q1.size(), N);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                check($sformatf("%s r%0d c%0d", tag, r, c), qv(inst, r * W + c), 32'(model(bg, r, c)));
    endtask

    initial begin
        rst = 1'b1;
        v0 = 1'b0; v1 = 1'b0; p0 = 8'h00; p1 = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset valid0", ov0, 0);
        check("reset valid1", ov1, 0);
        check("reset pix0", po0, 0);
        check("reset pix1", po1, 0);
        rst = 1'b0;

        fill_img(8'hFF);
        send(1, 0, "white");
        check_frame(1, 1, "white");
        check("white first", qv(1, 0), 32'hFF);
        check("white last", qv(1, N - 1), 32'hFF);

        // Non-binary value counts as black.
        fill_img(8'hFF);
        img[10][10] = 8'hFE;
        send(1, 0, "dot");
        check_frame(1, 1, "dot");
        check("dot 9,9", qv(1, 9 * W + 9), 32'h00);
        check("dot 11,11", qv(1, 11 * W + 11), 32'h00);
        check("dot 10,12", qv(1, 10 * W + 12), 32'hFF);
        check("dot 8,10", qv(1, 8 * W + 10), 32'hFF);

        fill_img(8'h00);
        img[0][0] = 8'hFF;
        send(0, 0, "bg0");
        check_frame(0, 0, "bg0");
        check("bg0 0,0", qv(0, 0), 32'hFF);
        check("bg0 0,1", qv(0, 1), 32'hFF);
        check("bg0 1,0", qv(0, W), 32'hFF);
        check("bg0 1,1", qv(0, W + 1), 32'hFF);
        check("bg0 0,2", qv(0, 2), 32'h00);
        check("bg0 0,last", qv(0, W - 1), 32'h00);
        check("bg0 lastrow,0", qv(0, (H - 1) * W), 32'h00);

        fill_img(8'hFF);
        img[5][W-1] = 8'h00;
        send(1, 0, "edge");
        check_frame(1, 1, "edge");
        check("edge 4,W-2", qv(1, 4 * W + W - 2), 32'h00);
        check("edge 6,W-1", qv(1, 6 * W + W - 1), 32'h00);
        check("edge 5,0", qv(1, 5 * W), 32'hFF);
        check("edge 6,0", qv(1, 6 * W), 32'hFF);
        check("edge 7,0", qv(1, 7 * W), 32'hFF);

        fill_img(8'hFF);
        img[10][10] = 8'h00;
        send(1, 1, "gaps");
        check_frame(1, 1, "gaps");
        check("gaps 10,10", qv(1, 10 * W + 10), 32'h00);

        for (int k = 0; k < N / 2; k++) begin
            @(negedge clk);
            drive(1, 1'b1, (k % 3 == 0) ? 8'h00 : 8'hFF);
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset valid a", ov1, 0);
        check("midreset pix a", po1, 0);
        @(posedge clk);
        @(negedge clk);
        check("midreset valid b", ov1, 0);
        check("midreset pix b", po1, 0);
        rst = 1'b0;
        drive(1, 1'b0, 8'h00);
        @(negedge clk);
        send(1, 0, "after_rst");
        check_frame(1, 1, "after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
